// File: rtl/seg7_readback.sv
// seg7_readback: monitor path that turns the scanned, active-low 7-segment
// bus back into hex nibbles.
//
// Each (segment, anode) pair is registered, and a capture event fires once
// the pair has stayed unchanged for STABLE_CYCLES samples. The event is
// ignored unless the anode is one-hot. It is then decoded against the
// inverse of the standard hex-to-segment table, written into a per-digit
// shadow bank, and offered on a valid/ready stream when the digit's value
// is new or has changed.
//
// Optional feature: define SEG7_RB_BLANK_EN to accept the all-segments-off
// pattern (7'b1111111) as a legal "blank". A blank clears the digit's
// bank_valid bit. With the macro undefined, that pattern is undecodable and
// pulses bad_pattern.
//
// digit_idx is 3 bits wide, so DIGITS may be at most 8.

module seg7_readback #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic                  digit_valid,
    input  logic                  digit_ready,
    output logic [2:0]            digit_idx,
    output logic [3:0]            digit_val,
    output logic [4*DIGITS-1:0]   hex_bank,
    output logic [DIGITS-1:0]     bank_valid,
    output logic                  bad_pattern,
    output logic                  overrun
);

    // Stability counter width: it only has to reach STABLE_CYCLES-1.
    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
    localparam int ZW = $clog2(DIGITS + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Input stage and settle detection
    // ------------------------------------------------------------------
    logic [6:0]        s_seg;
    logic [DIGITS-1:0] s_an;
    logic [CNT_W-1:0]  stab_cnt;
    logic              arm;       // capture event, valid for one cycle
    logic              sample_changed;

    assign sample_changed = (seg_in != s_seg) || (an_in != s_an);

    // Register the bus every cycle and count how long the pair has stayed put;
    // arm fires on the single cycle the count first reaches its saturation value.
    always_ff @(posedge clk) begin
        // NOTE: every register in a clocked block takes a non-blocking
        // assignment, so all of them update from the same pre-edge values.
        if (rst) begin
            s_seg    <= '1;
            s_an     <= '1;
            stab_cnt <= '0;
            arm      <= 1'b0;
        end else begin
            s_seg <= seg_in;
            s_an  <= an_in;
            if (sample_changed) begin
                stab_cnt <= '0;
                arm      <= 1'b0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
                arm      <= (stab_cnt == CNT_PRE);
            end else begin
                arm      <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Anode check: exactly one active (zero) bit selects the digit
    // ------------------------------------------------------------------
    logic [ZW-1:0] an_zeros;
    logic [2:0]    an_idx;
    logic          an_one_hot;

    // Count the active anodes and remember which one is active.
    always_comb begin
        // NOTE: every variable gets a default before the loop and the
        // branches, so no path leaves it unassigned and no latch is inferred.
        an_zeros = '0;
        an_idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!s_an[i]) begin
                an_zeros = an_zeros + 1'b1;
                an_idx   = 3'(i);
            end
        end
    end

    assign an_one_hot = (an_zeros == ZW'(1));

    // ------------------------------------------------------------------
    // Segment decode: inverse of the hex-to-segment encoding (bit6=g..bit0=a)
    // ------------------------------------------------------------------
    logic       dec_ok;
    logic [3:0] dec_val;
    logic       seg_blank;

    // Map the settled segment pattern back to its hex value.
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (s_seg)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    assign seg_blank = (s_seg == 7'b1111111);

    // ------------------------------------------------------------------
    // Event qualification
    // ------------------------------------------------------------------
    logic       ev_digit;     // settled pattern addressed to one digit
    logic       ev_good;      // ... and it decodes
    logic [3:0] bank_cur;     // current shadow nibble of that digit
    logic       offer;        // decoded value is new or changed

    assign ev_digit = arm && an_one_hot;
    assign ev_good  = ev_digit && dec_ok;
    assign bank_cur = hex_bank[{an_idx, 2'b00} +: 4];
    assign offer    = ev_good && (!bank_valid[an_idx] || (bank_cur != dec_val));

    // ------------------------------------------------------------------
    // Shadow bank and bad-pattern pulse
    // ------------------------------------------------------------------

    // Write decoded values into the bank; flag undecodable captures for one cycle.
    always_ff @(posedge clk) begin
        // NOTE: the bank is a handful of flops observed directly on the
        // ports, so it is cleared by reset like any other state register.
        if (rst) begin
            hex_bank    <= '0;
            bank_valid  <= '0;
            bad_pattern <= 1'b0;
        end else begin
            bad_pattern <= 1'b0;
            if (ev_digit) begin
                if (dec_ok) begin
                    hex_bank[{an_idx, 2'b00} +: 4] <= dec_val;
                    bank_valid[an_idx]             <= 1'b1;
                end
`ifdef SEG7_RB_BLANK_EN
                else if (seg_blank) begin
                    // Blanked digit: forget it was valid, keep the last nibble.
                    bank_valid[an_idx] <= 1'b0;
                end
`endif
                else begin
                    bad_pattern <= 1'b1;
                end
            end
        end
    end

`ifndef SEG7_RB_BLANK_EN
    // Without the blank feature the all-off pattern is just another
    // undecodable value handled by the default decode path above.
    logic unused_blank;
    assign unused_blank = seg_blank;
`endif

    // ------------------------------------------------------------------
    // Output stream FSM
    // ------------------------------------------------------------------
    state_t state;

    // Hold one item until accepted; anything offered meanwhile is dropped
    // and remembered in the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            digit_valid <= 1'b0;
            digit_idx   <= '0;
            digit_val   <= '0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (offer) begin
                        digit_idx   <= an_idx;
                        digit_val   <= dec_val;
                        digit_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (offer) begin
                        overrun <= 1'b1;
                    end
                    if (digit_ready) begin
                        digit_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    digit_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_readback.sv
// Testbench for seg7_readback: directed scenarios followed by random scans,
// every cycle compared against a rule-level model of the readback behaviour.

module tb_seg7_readback;

    localparam int DIGITS = 8;
    localparam int S      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [6:0]            seg_in;
    logic [DIGITS-1:0]     an_in;
    logic                  digit_valid;
    logic                  digit_ready;
    logic [2:0]            digit_idx;
    logic [3:0]            digit_val;
    logic [4*DIGITS-1:0]   hex_bank;
    logic [DIGITS-1:0]     bank_valid;
    logic                  bad_pattern;
    logic                  overrun;

    seg7_readback #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_idx   (digit_idx),
        .digit_val   (digit_val),
        .hex_bank    (hex_bank),
        .bank_valid  (bank_valid),
        .bad_pattern (bad_pattern),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Hex-to-segment encoding (active-low, bit6=g .. bit0=a).
    logic [6:0] enc [16];

    // Reference model state.
    // hist holds the last S+1 input pairs seen at clock edges; bit 15 marks
    // the "unknown history" sentinel that follows a reset.
    logic [15:0]       hist [0:S];
    logic [3:0]        m_bank [DIGITS];
    logic [DIGITS-1:0] m_bv;
    logic              m_pend;
    logic [2:0]        m_idx;
    logic [3:0]        m_val;
    logic              m_bad;
    logic              m_ovr;

    int acc_obs  = 0;   // accepted stream items seen on the DUT ports
    int badp_obs = 0;   // bad_pattern cycles seen on the DUT ports

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < S; i++) hist[i] = 16'h8000;
        hist[S] = {1'b0, 7'h7F, 8'hFF};
        for (int i = 0; i < DIGITS; i++) m_bank[i] = 4'h0;
        m_bv   = '0;
        m_pend = 1'b0;
        m_idx  = '0;
        m_val  = '0;
        m_bad  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One clock edge of the model: a capture happens when the last S samples
    // agree and the sample before them differed.
    task automatic model_edge(input logic [6:0] seg, input logic [7:0] an, input logic rdy);
        logic       fire;
        logic       offer;
        logic [6:0] c_seg;
        logic [7:0] c_an;
        int         zeros;
        int         idx;
        int         val;
        fire  = (hist[0] != hist[1]);
        for (int i = 1; i < S; i++) if (hist[i] != hist[S]) fire = 1'b0;
        offer = 1'b0;
        m_bad = 1'b0;
        idx   = 0;
        val   = -1;
        if (fire) begin
            c_seg = hist[S][14:8];
            c_an  = hist[S][7:0];
            zeros = 0;
            for (int i = 0; i < DIGITS; i++) if (!c_an[i]) begin zeros++; idx = i; end
            if (zeros == 1) begin
                for (int v = 0; v < 16; v++) if (enc[v] == c_seg) val = v;
                if (val >= 0) begin
                    offer = !m_bv[idx] || (m_bank[idx] != 4'(val));
                    m_bank[idx] = 4'(val);
                    m_bv[idx]   = 1'b1;
                end else begin
`ifdef SEG7_RB_BLANK_EN
                    if (c_seg == 7'h7F) m_bv[idx] = 1'b0;
                    else m_bad = 1'b1;
`else
                    m_bad = 1'b1;
`endif
                end
            end
        end
        if (m_pend) begin
            if (offer) m_ovr = 1'b1;
            if (rdy) m_pend = 1'b0;
        end else if (offer) begin
            m_pend = 1'b1;
            m_idx  = 3'(idx);
            m_val  = 4'(val);
        end
        for (int i = 0; i < S; i++) hist[i] = hist[i+1];
        hist[S] = {1'b0, seg, an};
    endtask

    // Drive one cycle of inputs, advance the model and compare every output.
    task automatic step(input logic [6:0] seg, input logic [7:0] an, input logic rdy);
        logic [31:0] exp_bank;
        seg_in      = seg;
        an_in       = an;
        digit_ready = rdy;
        if (!rst && digit_valid && rdy) acc_obs++;
        @(posedge clk);
        if (rst) m_reset();
        else model_edge(seg, an, rdy);
        #1;
        if (bad_pattern) badp_obs++;
        exp_bank = '0;
        for (int i = 0; i < DIGITS; i++) exp_bank[4*i +: 4] = m_bank[i];
        check("digit_valid", 32'(digit_valid), 32'(m_pend));
        check("digit_idx",   32'(digit_idx),   32'(m_idx));
        check("digit_val",   32'(digit_val),   32'(m_val));
        check("hex_bank",    hex_bank,         exp_bank);
        check("bank_valid",  32'(bank_valid),  32'(m_bv));
        check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
        check("overrun",     32'(overrun),     32'(m_ovr));
    endtask

    task automatic hold(input logic [6:0] seg, input logic [7:0] an, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(seg, an, rdy);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        hold(7'h7F, 8'hFF, 1'b0, n);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] an_sel(input int d);
        an_sel = ~(8'h01 << d);
    endfunction

    int acc0;
    int bad0;

    initial begin
        enc = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst         = 1'b1;
        seg_in      = 7'h7F;
        an_in       = 8'hFF;
        digit_ready = 1'b0;
        m_reset();

        // Reset state.
        do_reset(3);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_bank",  hex_bank,         32'd0);
        check("rst_bv",    32'(bank_valid),  32'd0);
        check("rst_ovr",   32'(overrun),     32'd0);
        hold(7'h7F, 8'hFF, 1'b1, 3);

        // Digit "1" on digit 2, latency k+S.
        acc0 = acc_obs;
        step(7'h79, 8'hFB, 1'b1);
        hold(7'h79, 8'hFB, 1'b1, 3);
        check("t1_before_latency", 32'(digit_valid), 32'd0);
        step(7'h79, 8'hFB, 1'b1);
        check("t1_valid_at_k4", 32'(digit_valid), 32'd1);
        check("t1_idx", 32'(digit_idx), 32'd2);
        check("t1_val", 32'(digit_val), 32'd1);
        hold(7'h79, 8'hFB, 1'b1, 5);
        check("t1_accepts", 32'(acc_obs - acc0), 32'd1);
        check("t1_bank", 32'(hex_bank[11:8]), 32'd1);
        check("t1_bv2", 32'(bank_valid[2]), 32'd1);

        // Glitch rejection: 3-cycle pattern on digit 0 between blanked anodes.
        bad0 = badp_obs;
        hold(7'h7F, 8'hFF, 1'b1, 5);
        hold(7'h24, 8'hFE, 1'b1, 3);
        hold(7'h7F, 8'hFF, 1'b1, 6);
        check("glitch_bv0", 32'(bank_valid[0]), 32'd0);
        check("glitch_bad", 32'(badp_obs - bad0), 32'd0);

        // Full scan 0..7, then an identical scan producing no traffic.
        acc0 = acc_obs;
        for (int d = 0; d < DIGITS; d++) hold(enc[d], an_sel(d), 1'b1, 6);
        check("scan1_items", 32'(acc_obs - acc0), 32'd8);
        acc0 = acc_obs;
        for (int d = 0; d < DIGITS; d++) hold(enc[d], an_sel(d), 1'b1, 6);
        check("scan2_items", 32'(acc_obs - acc0), 32'd0);

        // Undecodable pattern on digit 5.
        bad0 = badp_obs;
        hold(7'b1010101, an_sel(5), 1'b1, 6);
        check("bad_pulses", 32'(badp_obs - bad0), 32'd1);
        check("bad_bv5", 32'(bank_valid[5]), 32'd1);

        // Backpressure: digit 0 held while digit 1 change is dropped.
        hold(enc[9], an_sel(0), 1'b0, 6);
        hold(enc[10], an_sel(1), 1'b0, 6);
        check("bp_valid", 32'(digit_valid), 32'd1);
        check("bp_idx",   32'(digit_idx),   32'd0);
        check("bp_val",   32'(digit_val),   32'd9);
        check("bp_ovr",   32'(overrun),     32'd1);
        check("bp_bank1", 32'(hex_bank[7:4]), 32'hA);
        hold(enc[10], an_sel(1), 1'b1, 2);
        check("bp_drop_valid", 32'(digit_valid), 32'd0);

        // Reset in the middle of a held item.
        hold(enc[12], an_sel(2), 1'b0, 6);
        check("mid_hold_valid", 32'(digit_valid), 32'd1);
        do_reset(2);
        check("mid_rst_valid", 32'(digit_valid), 32'd0);
        check("mid_rst_ovr",   32'(overrun),     32'd0);
        check("mid_rst_bv",    32'(bank_valid),  32'd0);

        // Blank pattern on digit 3 after a value of 7.
        hold(enc[7], an_sel(3), 1'b1, 6);
        bad0 = badp_obs;
        acc0 = acc_obs;
        hold(7'h7F, an_sel(3), 1'b1, 6);
        check("blank_bank3", 32'(hex_bank[15:12]), 32'd7);
        check("blank_items", 32'(acc_obs - acc0), 32'd0);
`ifdef SEG7_RB_BLANK_EN
        check("blank_bv3", 32'(bank_valid[3]), 32'd0);
        check("blank_bad", 32'(badp_obs - bad0), 32'd0);
`else
        check("blank_bv3", 32'(bank_valid[3]), 32'd1);
        check("blank_bad", 32'(badp_obs - bad0), 32'd1);
`endif

        // Random scans with random backpressure and malformed patterns.
        for (int g = 0; g < 120; g++) begin
            int         d;
            int         kind;
            int         len;
            logic [6:0] sg;
            logic [7:0] an;
            d    = $urandom_range(0, DIGITS - 1);
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 7);
            an   = an_sel(d);
            sg   = enc[$urandom_range(0, 15)];
            if (kind == 7) sg = 7'($urandom);
            if (kind == 8) an = 8'hFF;
            if (kind == 9) an = 8'($urandom);
            for (int c = 0; c < len; c++) step(sg, an, 1'($urandom_range(0, 1)));
        end
        hold(7'h7F, 8'hFF, 1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
